// File: rtl/calc_pkg.sv
// Shared opcode and state encodings for the sequential calculator core.
// State values double as the 4-bit display code driven on cs.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_EXEC = 4'd1,
    S_MUL  = 4'd2,
    S_DONE = 4'd3
  } state_t;

endpackage

// File: rtl/calc_core_seq_if.sv
// Request/result bundle between the switch/button front end and the calculator core.
interface calc_core_seq_if #(
  parameter int WIDTH = 4
);
  logic                 adv;
  logic                 go;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic [1:0]           op;
  logic [2*WIDTH-1:0]   out;
  logic                 ovf;
  logic                 done;
  logic                 busy;
  logic [3:0]           cs;

  modport master (
    output adv, go, in1, in2, op,
    input  out, ovf, done, busy, cs
  );

  modport slave (
    input  adv, go, in1, in2, op,
    output out, ovf, done, busy, cs
  );
endinterface

// File: rtl/calc_mul_seq.sv
// Shift-add multiplier: one partial product per enabled step, WIDTH steps per product.
// product is the accumulator value after the current step, so it is final when last=1.
module calc_mul_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 last
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplr;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   shamt;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_nxt;

  // Bit weight of the multiplier LSB grows as the counter runs down.
  assign shamt   = CNT_INIT - cnt;
  assign addend  = {{WIDTH{1'b0}}, a} << shamt;
  assign acc_nxt = mplr[0] ? (acc + addend) : acc;
  assign product = acc_nxt;
  assign last    = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      mplr <= '0;
      cnt  <= '0;
    end else if (start) begin
      acc  <= '0;
      mplr <= b;
      cnt  <= CNT_INIT;
    end else if (step_en && (cnt != '0)) begin
      acc  <= acc_nxt;
      mplr <= mplr >> 1;
      cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/calc_core_seq.sv
// Calculator core: operand capture, single-cycle ADD/SUB/AND, multi-cycle MUL,
// optionally stepped by the adv pulse instead of every clock.
module calc_core_seq
  import calc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SINGLE_STEP = 0
) (
  input  logic            clk,
  input  logic            rst,
  calc_core_seq_if.slave  bus
);
  state_t               state;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [1:0]           op_q;
  logic [2*WIDTH-1:0]   out_q;
  logic                 ovf_q;
  logic                 act;
  logic                 mul_start;
  logic                 mul_step;
  logic                 mul_last;
  logic [2*WIDTH-1:0]   mul_product;

  // Returns {ovf, out} for the single-cycle opcodes.
  function automatic logic [2*WIDTH:0] alu_result(input logic [1:0] opc,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   s;
    logic [2*WIDTH:0] res;
    s   = '0;
    res = '0;
    case (opc)
      OP_ADD: begin
        s   = {1'b0, a} + {1'b0, b};
        res = {s[WIDTH], {(WIDTH-1){1'b0}}, s};
      end
      OP_SUB: begin
        s   = {1'b0, a} - {1'b0, b};
        res = {s[WIDTH], {WIDTH{1'b0}}, s[WIDTH-1:0]};
      end
      OP_AND:  res = {1'b0, {WIDTH{1'b0}}, a & b};
      default: res = '0;
    endcase
    return res;
  endfunction

  assign act       = (SINGLE_STEP != 0) ? bus.adv : 1'b1;
  assign mul_start = act && (state == S_EXEC) && (op_q == OP_MUL);
  assign mul_step  = act && (state == S_MUL);

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .step_en (mul_step),
    .a       (a_q),
    .b       (b_q),
    .product (mul_product),
    .last    (mul_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (act) begin
      case (state)
        S_IDLE: if (bus.go) begin
          a_q   <= bus.in1;
          b_q   <= bus.in2;
          op_q  <= bus.op;
          state <= S_EXEC;
        end
        S_EXEC: if (op_q == OP_MUL) begin
          state <= S_MUL;
        end else begin
          {ovf_q, out_q} <= alu_result(op_q, a_q, b_q);
          state          <= S_DONE;
        end
        S_MUL: if (mul_last) begin
          out_q <= mul_product;
          ovf_q <= 1'b0;
          state <= S_DONE;
        end
        // Leaving DONE needs go low, so a held go cannot retrigger.
        S_DONE: if (!bus.go) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.ovf  = ovf_q;
  assign bus.cs   = state;
  assign bus.done = (state == S_DONE);
  assign bus.busy = (state == S_EXEC) || (state == S_MUL);

endmodule
